// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler sharing one 4x4 shift-add multiplier core
// among NREQ requesters, with stale-READY filtering and a WAIT-state watchdog.
module mult_share_sched #(
  parameter int NREQ = 4,
  parameter int TMO  = 31
) (
  input  logic              CK,
  input  logic              RN,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] a_in,
  input  logic [4*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [7:0]        prod,
  output logic              busy,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  output logic              mul_start,
  input  logic              mul_ready,
  input  logic [7:0]        mul_p
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] pick;
  logic [IW:0]   cand;
  logic          found;
  logic          armed;
  logic [CW-1:0] count;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    logic [IW-1:0] n;
    if (idx == IW'(NREQ - 1)) begin
      n = '0;
    end else begin
      n = idx + 1'b1;
    end
    return n;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First requesting line at or after rr_ptr, wrapping past NREQ-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end else begin
        cand = cand;
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end else begin
        found = found;
      end
    end
  end

  // Scheduler FSM; every output is registered here.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      win       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      prod      <= 8'h00;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= 4'h0;
      mul_b     <= 4'h0;
      armed     <= 1'b0;
      count     <= '0;
    end else begin
      done      <= '0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            win   <= pick;
            gnt   <= onehot(pick);
            mul_a <= a_in[{pick, 2'b00} +: 4];
            mul_b <= b_in[{pick, 2'b00} +: 4];
            busy  <= 1'b1;
            state <= S_LAUNCH;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          mul_start <= 1'b1;
          armed     <= 1'b0;
          count     <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // READY is only trusted once it has been seen low after START.
          if (!mul_ready) begin
            armed <= 1'b1;
          end else begin
            armed <= armed;
          end
          if (armed && mul_ready) begin
            prod  <= mul_p;
            state <= S_DONE;
          end else if (count == CW'(TMO)) begin
            err    <= 1'b1;
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_idx(win);
            state  <= S_IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          done   <= req[win] ? onehot(win) : '0;
          gnt    <= '0;
          busy   <= 1'b0;
          rr_ptr <= next_idx(win);
          state  <= S_IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
